// File: rtl/lsu_mem_ctrl.sv
// LSU memory sequencer: one load/store per instruction over a single-outstanding
// valid/ready port. Optional misaligned-access trap: define LSU_MISALIGN_CHECK_EN.

// state | meaning
// IDLE  | waiting for a valid instruction; non-memory ops pass straight through
// REQ   | request presented on the memory port until accepted
// RESP  | request accepted, waiting for the response
// DONE  | result held for WBU until it is accepted
module lsu_mem_ctrl #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic              i_MemEn,
    input  logic              i_MemWr,
    input  logic [2:0]        i_MemOP,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              lsu_ready,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_err,
    input  logic              wbu_allow_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    input  logic              mem_resp_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [OFF_W-1:0]  off;
    logic [1:0]        size;
    logic              misaligned;
    logic [STRB_W-1:0] strb_base;
    logic [XLEN-1:0]   shifted;
    logic              sext;
    logic [XLEN-1:0]   load_ext;

    assign off  = i_addr[OFF_W-1:0];
    assign size = i_MemOP[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = |i_addr[1:0];
            default: misaligned = |i_addr[2:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Request side: byte lanes beyond the bus width are simply shifted out.
    always_comb begin
        strb_base = '0;
        case (size)
            2'b00:   strb_base = STRB_W'(8'h01);
            2'b01:   strb_base = STRB_W'(8'h03);
            2'b10:   strb_base = STRB_W'(8'h0F);
            default: strb_base = '1;
        endcase
    end

    assign mem_req_wen   = i_MemWr;
    assign mem_req_addr  = {i_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wdata = i_wdata << {off, 3'b000};
    assign mem_req_wstrb = strb_base << off;

    assign shifted = mem_resp_rdata >> {off, 3'b000};
    assign sext    = ~i_MemOP[2];

    always_comb begin
        load_ext = shifted;
        case (size)
            2'b00:   load_ext = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
            2'b01:   load_ext = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
            2'b10:   load_ext = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        o_valid       = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_valid) begin
                    if (!i_MemEn) begin
                        o_valid = 1'b1;
                    end else if (misaligned) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (mem_resp_valid) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (wbu_allow_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu_ready = o_valid & wbu_allow_in;
    // Pass-through results in IDLE must read as zero regardless of the last load.
    assign o_rdata   = (state == DONE) ? rdata_q : '0;
    assign o_err     = (state == DONE) ? err_q : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RESP && mem_resp_valid) begin
                rdata_q <= i_MemWr ? '0 : load_ext;
                err_q   <= mem_resp_err;
            end else if (state == IDLE && lsu_valid && i_MemEn && misaligned) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan cases plus randomized
// transactions checked against a byte-level reference model.
module tb_lsu_mem_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            lsu_valid;
    logic            i_MemEn;
    logic            i_MemWr;
    logic [2:0]      i_MemOP;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_wdata;
    logic            lsu_ready;
    logic            o_valid;
    logic [XLEN-1:0] o_rdata;
    logic            o_err;
    logic            wbu_allow_in;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_wen;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wstrb;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_rdata;
    logic            mem_resp_err;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .i_MemEn        (i_MemEn),
        .i_MemWr        (i_MemWr),
        .i_MemOP        (i_MemOP),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .lsu_ready      (lsu_ready),
        .o_valid        (o_valid),
        .o_rdata        (o_rdata),
        .o_err          (o_err),
        .wbu_allow_in   (wbu_allow_in),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: work on byte lanes of the aligned 8-byte word.
    function automatic int m_size(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic [63:0] m_strb(input logic [2:0] op, input logic [63:0] a);
        logic [63:0] r;
        int off;
        r   = '0;
        off = int'(a[2:0]);
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + m_size(op)) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] wd);
        logic [63:0] r;
        int off;
        r   = '0;
        off = int'(a[2:0]);
        for (int k = 0; k < 8; k++)
            if (k >= off) r[8*k +: 8] = wd[8*(k-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic we, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] rd);
        logic [63:0] v;
        int off;
        int sz;
        v   = '0;
        off = int'(a[2:0]);
        sz  = m_size(op);
        if (we) return '0;
        for (int i = 0; i < sz; i++)
            if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!op[2] && sz < 8 && v[8*sz-1])
            for (int j = 8*sz; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] op, input logic [63:0] a);
        int sz;
        sz = m_size(op);
        return (int'(a[2:0]) % sz) != 0;
    endfunction

    // One memory instruction, inputs set right after the edge the previous one retired on.
    task automatic run_mem(input logic we, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd, input logic er,
                           input int rq_dly, input int rs_dly, input int al_dly);
        logic [63:0] exp_rd;
        exp_rd         = m_load(we, op, a, rd);
        lsu_valid      = 1'b1;
        i_MemEn        = 1'b1;
        i_MemWr        = we;
        i_MemOP        = op;
        i_addr         = a;
        i_wdata        = wd;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        wbu_allow_in   = 1'($urandom_range(0, 1));
        #1;
        check("idle_o_valid", 64'(o_valid), 64'd0);
        check("idle_req_valid", 64'(mem_req_valid), 64'd0);
        check("idle_lsu_ready", 64'(lsu_ready), 64'd0);
        tick();
        wbu_allow_in = 1'b0;
        for (int i = 0; i <= rq_dly; i++) begin
            mem_req_ready = (i == rq_dly);
            #1;
            check("req_valid", 64'(mem_req_valid), 64'd1);
            check("req_addr", mem_req_addr, a & ~64'h7);
            check("req_wen", 64'(mem_req_wen), 64'(we));
            check("req_wstrb", 64'(mem_req_wstrb), m_strb(op, a));
            check("req_wdata", mem_req_wdata, m_wdata(a, wd));
            check("req_o_valid", 64'(o_valid), 64'd0);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i <= rs_dly; i++) begin
            if (i == rs_dly) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rd;
                mem_resp_err   = er;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_rdata = {$urandom, $urandom};
                mem_resp_err   = 1'($urandom_range(0, 1));
            end
            wbu_allow_in = 1'($urandom_range(0, 1));
            #1;
            check("resp_req_valid", 64'(mem_req_valid), 64'd0);
            check("resp_o_valid", 64'(o_valid), 64'd0);
            check("resp_lsu_ready", 64'(lsu_ready), 64'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        for (int i = 0; i <= al_dly; i++) begin
            wbu_allow_in   = (i == al_dly);
            mem_resp_rdata = {$urandom, $urandom};
            mem_resp_err   = 1'($urandom_range(0, 1));
            #1;
            check("done_o_valid", 64'(o_valid), 64'd1);
            check("done_o_rdata", o_rdata, exp_rd);
            check("done_o_err", 64'(o_err), 64'(er));
            check("done_lsu_ready", 64'(lsu_ready), 64'(i == al_dly));
            check("done_req_valid", 64'(mem_req_valid), 64'd0);
            tick();
        end
        wbu_allow_in = 1'b0;
    endtask

    task automatic run_alu(input int al_dly);
        lsu_valid      = 1'b1;
        i_MemEn        = 1'b0;
        i_MemWr        = 1'($urandom_range(0, 1));
        i_MemOP        = 3'($urandom_range(0, 7));
        i_addr         = {$urandom, $urandom};
        i_wdata        = {$urandom, $urandom};
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_valid = 1'b0;
        for (int i = 0; i <= al_dly; i++) begin
            wbu_allow_in = (i == al_dly);
            #1;
            check("alu_o_valid", 64'(o_valid), 64'd1);
            check("alu_o_rdata", o_rdata, 64'd0);
            check("alu_o_err", 64'(o_err), 64'd0);
            check("alu_lsu_ready", 64'(lsu_ready), 64'(i == al_dly));
            check("alu_req_valid", 64'(mem_req_valid), 64'd0);
            tick();
        end
        wbu_allow_in = 1'b0;
    endtask

    task automatic idle_cycle();
        lsu_valid      = 1'b0;
        i_MemEn        = 1'($urandom_range(0, 1));
        wbu_allow_in   = 1'($urandom_range(0, 1));
        mem_resp_valid = 1'b0;
        #1;
        check("bubble_o_valid", 64'(o_valid), 64'd0);
        check("bubble_lsu_ready", 64'(lsu_ready), 64'd0);
        check("bubble_req_valid", 64'(mem_req_valid), 64'd0);
        tick();
    endtask

    initial begin
        logic        we;
        logic [2:0]  op;
        logic [63:0] a;

        rst            = 1'b0;
        lsu_valid      = 1'b0;
        i_MemEn        = 1'b0;
        i_MemWr        = 1'b0;
        i_MemOP        = 3'd0;
        i_addr         = '0;
        i_wdata        = '0;
        wbu_allow_in   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_err   = 1'b0;
        tick();
        tick();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_rdata", o_rdata, 64'd0);
        check("rst_o_err", 64'(o_err), 64'd0);
        rst = 1'b1;
        tick();

        // lb sign-extended, minimum latency
        run_mem(1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0);
        // sh into the top half-word
        run_mem(1'b1, 3'b001, 64'h8000_0006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 0);
        // back-pressure on every handshake
        run_mem(1'b0, 3'b011, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 2, 2);
        // non-memory then lwu back-to-back
        run_alu(0);
        run_mem(1'b0, 3'b110, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1'b0, 0, 0, 0);
        run_alu(2);
        // bus error reported on a load
        run_mem(1'b0, 3'b010, 64'h8000_0000, 64'h0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1, 0, 0);

        // reset while waiting for the response, then a stray late response
        lsu_valid     = 1'b1;
        i_MemEn       = 1'b1;
        i_MemWr       = 1'b0;
        i_MemOP       = 3'b011;
        i_addr        = 64'h8000_0020;
        mem_req_ready = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst           = 1'b0;
        tick();
        rst       = 1'b1;
        lsu_valid = 1'b0;
        #1;
        check("rstmid_o_valid", 64'(o_valid), 64'd0);
        check("rstmid_req_valid", 64'(mem_req_valid), 64'd0);
        check("rstmid_o_err", 64'(o_err), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        mem_resp_err   = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("late_resp_o_valid", 64'(o_valid), 64'd0);
        check("late_resp_o_err", 64'(o_err), 64'd0);
        check("late_resp_req_valid", 64'(mem_req_valid), 64'd0);
        idle_cycle();

        // lw at a half-word offset
`ifdef LSU_MISALIGN_CHECK_EN
        lsu_valid     = 1'b1;
        i_MemEn       = 1'b1;
        i_MemWr       = 1'b0;
        i_MemOP       = 3'b010;
        i_addr        = 64'h8000_0002;
        mem_req_ready = 1'b1;
        wbu_allow_in  = 1'b0;
        #1;
        check("mis_idle_req_valid", 64'(mem_req_valid), 64'd0);
        tick();
        wbu_allow_in = 1'b1;
        #1;
        check("mis_o_valid", 64'(o_valid), 64'd1);
        check("mis_o_err", 64'(o_err), 64'd1);
        check("mis_o_rdata", o_rdata, 64'd0);
        check("mis_req_valid", 64'(mem_req_valid), 64'd0);
        tick();
        mem_req_ready = 1'b0;
        wbu_allow_in  = 1'b0;
`else
        run_mem(1'b0, 3'b010, 64'h8000_0002, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 0, 0, 0);
        check("mis_wstrb_value", m_strb(3'b010, 64'h8000_0002), 64'h3C);
`endif

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: run_alu(int'($urandom_range(0, 2)));
                1: idle_cycle();
                default: begin
                    we = 1'($urandom_range(0, 1));
                    op = 3'($urandom_range(0, 7));
                    a  = {$urandom, $urandom};
`ifdef LSU_MISALIGN_CHECK_EN
                    if (m_misaligned(op, a)) a[2:0] = 3'b000;
`else
                    if (m_misaligned(op, a) && $urandom_range(0, 1) == 0) a[2:0] = 3'b000;
`endif
                    run_mem(we, op, a, {$urandom, $urandom}, {$urandom, $urandom},
                            1'($urandom_range(0, 3) == 0),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 2)));
                end
            endcase
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
